// File: rtl/input_conditioner.sv
// Push-button input conditioner: a two-flop synchronizer followed by a
// four-state debounce FSM. Produces a registered debounced level (X_OUT)
// and a registered one-cycle press event (X_PULSE) for downstream logic.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic BTN_IN,
  output logic X_OUT,
  output logic X_PULSE
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Count value on which the next agreeing sample completes confirmation.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,  // stable released
    CHK_HI = 2'b01,  // confirming a press
    HIGH   = 2'b10,  // stable pressed
    CHK_LO = 2'b11   // confirming a release
  } state_t;

  logic          sync1;
  logic          sync2;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          x_out_nxt;
  logic          x_pulse_nxt;

  // Two-flop synchronizer; only sync2 is visible to the debounce logic.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= BTN_IN;
      sync2 <= sync1;
    end
  end

  // State, sample counter and registered outputs, all on the same edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      X_OUT   <= 1'b0;
      X_PULSE <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      X_OUT   <= x_out_nxt;
      X_PULSE <= x_pulse_nxt;
    end
  end

  // Next-state, next-count and next-output decode. The count never exceeds
  // CNT_LAST, because reaching it with an agreeing sample always leaves the
  // confirming state and clears the count.
  always_comb begin
    state_nxt   = IDLE;
    cnt_nxt     = '0;
    x_pulse_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = IDLE;
        end
      end

      CHK_HI: begin
        if (!sync2) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = HIGH;
          x_pulse_nxt = 1'b1;
        end else begin
          state_nxt = CHK_HI;
          cnt_nxt   = cnt + CNT_ONE;
        end
      end

      HIGH: begin
        if (!sync2) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = HIGH;
        end
      end

      CHK_LO: begin
        if (sync2) begin
          state_nxt = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = CHK_LO;
          cnt_nxt   = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    x_out_nxt = (state_nxt == HIGH) || (state_nxt == CHK_LO);
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4. The driver
// applies one input vector per clock and pushes the hand-derived expected
// outputs for that edge; a monitor pops and compares on the falling edge.
module tb_input_conditioner;

  logic CLK = 1'b0;
  logic nRST;
  logic BTN_IN;
  logic X_OUT;
  logic X_PULSE;

  always #5 CLK = ~CLK;

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .BTN_IN (BTN_IN),
    .X_OUT  (X_OUT),
    .X_PULSE(X_PULSE)
  );

  typedef struct {
    logic  eo;
    logic  ep;
    string tag;
    int    ed;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  // Drive one vector, let one rising edge consume it, queue the expectation.
  task automatic cyc(input logic btn, input logic rst_n, input logic eo,
                     input logic ep, input string tag, input int ed);
    exp_t e;
    BTN_IN = btn;
    nRST   = rst_n;
    @(posedge CLK);
    e.eo  = eo;
    e.ep  = ep;
    e.tag = tag;
    e.ed  = ed;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: compare registered outputs mid-cycle against the queue head.
  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        if (X_OUT === mon_e.eo) passes++;
        else $display("FAIL %s.x_out edge %0d: got %b expected %b",
                      mon_e.tag, mon_e.ed, X_OUT, mon_e.eo);
        checks++;
        if (X_PULSE === mon_e.ep) passes++;
        else $display("FAIL %s.x_pulse edge %0d: got %b expected %b",
                      mon_e.tag, mon_e.ed, X_PULSE, mon_e.ep);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    BTN_IN = 1'b0;
    nRST   = 1'b0;

    // Reset with button released.
    for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset", k);

    // Clean press sampled at edge 10, held 20 cycles, released at edge 30:
    // X_OUT rises after edge 15, falls after edge 35; one pulse at 15 only.
    for (int k = 1; k <= 40; k++)
      cyc(k >= 10 && k <= 29, 1'b1, k >= 15 && k <= 34, k == 15, "press", k);

    // Bounce 1,1,0,1,1,1,0...: never DEBOUNCE_CYCLES agreeing samples.
    for (int k = 1; k <= 15; k++)
      cyc((k <= 2) || (k >= 4 && k <= 6), 1'b1, 1'b0, 1'b0, "bounce", k);

    // Exactly four high samples: accepted after edge 6, released after 10.
    for (int k = 1; k <= 14; k++)
      cyc(k <= 4, 1'b1, k >= 6 && k <= 9, k == 6, "exact4", k);

    // Button held from edge 10; reset at 14 restarts confirmation (pulse 20);
    // reset at 25 while HIGH drops X_OUT, second pulse six edges later (31);
    // release glitches of 2 and 3 samples at 36-37 and 42-44 are ignored.
    for (int k = 1; k <= 50; k++)
      cyc(k >= 10 && !(k == 36 || k == 37 || k == 42 || k == 43 || k == 44),
          !(k == 14 || k == 25),
          (k >= 20 && k <= 24) || k >= 31,
          k == 20 || k == 31, "rst_mid", k);

    // Reset from HIGH with button released.
    for (int k = 1; k <= 2; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset2", k);

    // Reset lands on the edge that would complete confirmation (edge 6):
    // no pulse there; button still held so re-debounce pulses at edge 12.
    for (int k = 1; k <= 15; k++)
      cyc(1'b1, !(k == 6), k >= 12, k == 12, "rst_hit", k);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge CLK);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
